// File: rtl/hawk_fm_encoder_if.sv
// Bit-stream handshake between the upstream read stage and the FM encoder.
interface hawk_fm_encoder_if;
    logic in_valid;
    logic in_data;
    logic in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/hawk_fm_encoder.sv
// Serial bit stream -> composite Hawk FM read waveform (clock pulse per cell, extra mid-cell pulse for '1').
// Optional zero-cell preamble after enable: define HAWK_FM_ENC_PREAMBLE_EN.
module hawk_fm_encoder #(
    parameter int CELL_CYCLES    = 50,
    parameter int CLOCK_AT       = 0,
    parameter int DATA_AT        = 25,
    parameter int PULSE_WIDTH    = 5,
    parameter int FIFO_DEPTH     = 4,
    parameter int PREAMBLE_CELLS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    hawk_fm_encoder_if.slave         s_in,
    output logic                     o_fm_out,
    output logic                     o_cell_strobe,
    output logic                     o_underrun,
    output logic                     o_busy
);
    localparam int PH_W  = $clog2(CELL_CYCLES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CELL_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_CLK  = PH_W'(CLOCK_AT);
    localparam logic [PH_W-1:0]  PH_DAT  = PH_W'(DATA_AT);
    localparam logic [PH_W-1:0]  PH_PW   = PH_W'(PULSE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    if (CLOCK_AT + PULSE_WIDTH > DATA_AT) begin : g_bad_clock_window
        $fatal(1, "clock pulse overlaps data pulse");
    end
    if (DATA_AT + PULSE_WIDTH > CELL_CYCLES) begin : g_bad_data_window
        $fatal(1, "data pulse overruns the cell");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be at least 2");
    end
    if (PREAMBLE_CELLS < 1) begin : g_bad_preamble
        $fatal(1, "PREAMBLE_CELLS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef HAWK_FM_ENC_PREAMBLE_EN
        S_PRE,
`endif
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PH_W-1:0]    r_phase;
    logic               r_cur_bit;
    logic               r_underrun;
    logic               r_fm_out;
    logic [FIFO_DEPTH-1:0] r_mem;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_cell_end;
    logic               w_run_cell0;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_start;
    logic               w_in_ready;
    logic               w_fm_next;
    logic [PH_W-1:0]    w_off_clk;
    logic [PH_W-1:0]    w_off_dat;

`ifdef HAWK_FM_ENC_PREAMBLE_EN
    localparam int PRE_W = $clog2(PREAMBLE_CELLS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_CELLS - 1);
    logic [PRE_W-1:0]   r_pre_cnt;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cell_end   = (r_phase == PH_LAST);
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
`ifdef HAWK_FM_ENC_PREAMBLE_EN
                    w_state_next = S_PRE;
`else
                    w_state_next = S_RUN;
`endif
                end
            end
`ifdef HAWK_FM_ENC_PREAMBLE_EN
            S_PRE: begin
                if (w_cell_end) begin
                    if (!i_en)                       w_state_next = S_IDLE;
                    else if (r_pre_cnt == PRE_LAST)  w_state_next = S_RUN;
                end
            end
`endif
            S_RUN: begin
                if (w_cell_end && !i_en) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Offsets wrap modulo 2**PH_W, so one unsigned compare tests each pulse window.
    always_comb begin
        w_in_ready  = i_en && (r_count < CNT_MAX);
        w_push      = s_in.in_valid && w_in_ready;
        w_run_cell0 = (r_state == S_RUN) && (r_phase == '0);
        w_pop       = w_run_cell0 && (r_count != '0);
        w_flush     = (r_state != S_IDLE) && (w_state_next == S_IDLE);
        w_start     = (r_state == S_IDLE) && i_en;
        w_off_clk   = r_phase - PH_CLK;
        w_off_dat   = r_phase - PH_DAT;
        w_fm_next   = (r_state != S_IDLE) &&
                      ((w_off_clk < PH_PW) || (r_cur_bit && (w_off_dat < PH_PW)));
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_cur_bit  <= 1'b0;
            r_underrun <= 1'b0;
            r_fm_out   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_fm_out <= w_fm_next;

            if (r_state == S_IDLE || w_cell_end) r_phase <= '0;
            else                                 r_phase <= r_phase + PH_W'(1);

            if (w_run_cell0)             r_cur_bit <= w_pop ? r_mem[r_rd_ptr] : 1'b0;
            else if (r_state == S_IDLE)  r_cur_bit <= 1'b0;

            if (w_start)                          r_underrun <= 1'b0;
            else if (w_run_cell0 && !w_pop)       r_underrun <= 1'b1;

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
                else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef HAWK_FM_ENC_PREAMBLE_EN
    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE)        r_pre_cnt <= '0;
        else if (r_state == S_PRE && w_cell_end) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
`endif

    assign s_in.in_ready = w_in_ready;
    assign o_fm_out      = r_fm_out;
    assign o_cell_strobe = (r_state != S_IDLE) && (r_phase == '0);
    assign o_underrun    = r_underrun;
    assign o_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_hawk_fm_encoder.sv
// Randomized bench for hawk_fm_encoder against a cell-level reference model (bit queue + phase count).
module tb_hawk_fm_encoder;
    localparam int CELL   = 50;
    localparam int CLK_AT = 0;
    localparam int DAT_AT = 25;
    localparam int PW     = 5;
    localparam int DEPTH  = 4;
`ifdef HAWK_FM_ENC_PREAMBLE_EN
    localparam int PRE_N  = 32;
`else
    localparam int PRE_N  = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic fm_out, cell_strobe, underrun, busy;

    hawk_fm_encoder_if bus();

    hawk_fm_encoder #(
        .CELL_CYCLES    (CELL),
        .CLOCK_AT       (CLK_AT),
        .DATA_AT        (DAT_AT),
        .PULSE_WIDTH    (PW),
        .FIFO_DEPTH     (DEPTH),
        .PREAMBLE_CELLS (32)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_en          (en),
        .s_in          (bus),
        .o_fm_out      (fm_out),
        .o_cell_strobe (cell_strobe),
        .o_underrun    (underrun),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: encoder active flag, phase within cell, bit being sent, FIFO as a queue.
    bit m_act   = 1'b0;
    int m_phase = 0;
    bit m_cur   = 1'b0;
    bit m_under = 1'b0;
    bit m_fm    = 1'b0;
    int m_pre   = 0;
    bit q[$];

    // Called at a negedge; applies inputs, checks outputs, advances model at posedge.
    task automatic step(input bit rst, input bit e, input bit v, input bit d);
        bit exp_ready, push, fmn;
        reset = rst; en = e; bus.in_valid = v; bus.in_data = d;
        #1;
        exp_ready = e && (q.size() < DEPTH);
        check_val("in_ready",    bus.in_ready, exp_ready);
        check_val("busy",        busy,         m_act);
        check_val("cell_strobe", cell_strobe,  m_act && (m_phase == 0));
        check_val("underrun",    underrun,     m_under);
        check_val("fm_out",      fm_out,       m_fm);
        @(posedge clk);
        push = v && exp_ready;
        if (rst) begin
            m_act = 0; m_phase = 0; m_cur = 0; m_under = 0; m_fm = 0; m_pre = 0;
            q.delete();
        end else begin
            fmn = m_act && ((m_phase >= CLK_AT && m_phase < CLK_AT + PW) ||
                            (m_cur && m_phase >= DAT_AT && m_phase < DAT_AT + PW));
            if (!m_act) begin
                if (e) begin
                    m_act = 1; m_under = 0; m_phase = 0; m_pre = PRE_N;
                end
                m_cur = 0;
                if (push) q.push_back(d);
            end else begin
                if (m_phase == 0 && m_pre == 0) begin
                    if (q.size() > 0) m_cur = q.pop_front();
                    else begin m_cur = 0; m_under = 1; end
                end
                if (push) q.push_back(d);
                if (m_phase == CELL - 1) begin
                    m_phase = 0;
                    if (!e) begin m_act = 0; q.delete(); end
                    else if (m_pre > 0) m_pre--;
                end else m_phase++;
            end
            m_fm = fmn;
        end
        @(negedge clk);
    endtask

    bit e_r = 1'b0;
    bit v_r, rst_r;
    int hold = 0;
    int pv = 0;
    int guard;

    initial begin
        reset = 1'b1; en = 1'b0; bus.in_valid = 1'b0; bus.in_data = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_fm_out",   fm_out,       0);
        check_val("rst_strobe",   cell_strobe,  0);
        check_val("rst_underrun", underrun,     0);
        check_val("rst_busy",     busy,         0);
        check_val("rst_in_ready", bus.in_ready, 0);

        // Bits 1,0,1 at enable, then starve the FIFO to reach clock-only cells.
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        for (int i = 0; i < 6 * CELL + PRE_N * CELL; i++) step(0, 1, 0, 0);
        // Drop en mid-cell, then restart with the FIFO held full.
        for (int i = 0; i < 60; i++) step(0, 0, 0, 0);
        e_r = 1'b1;
        for (int i = 0; i < 8 * CELL; i++) step(0, 1, 1, 1'($urandom_range(0, 1)));

        for (int c = 0; c < 30000; c++) begin
            if (hold == 0) begin
                e_r  = !e_r;
                hold = e_r ? $urandom_range(150, 1500) + PRE_N * CELL : $urandom_range(1, 90);
                pv   = $urandom_range(0, 3);
            end else hold--;
            rst_r = ($urandom_range(0, 2999) == 0);
            case (pv)
                0:       v_r = 1'b0;
                1:       v_r = ($urandom_range(0, 59) == 0);
                2:       v_r = ($urandom_range(0, 29) == 0);
                default: v_r = 1'b1;
            endcase
            step(rst_r, e_r, v_r, 1'($urandom_range(0, 1)));
        end

        // Reset landing inside the data pulse of a '1' cell.
        guard = 0;
        while (!(m_act && m_cur && m_phase == DAT_AT + 2) && guard < 4000) begin
            step(0, 1, 1, 1);
            guard++;
        end
        check_val("reach_rst_in_data_pulse", guard < 4000, 1);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check_val("post_rst_fm_out", fm_out, 0);
        check_val("post_rst_busy",   busy,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
